mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 41 ++++
 rtl/mem_arbiter.sv | 177 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter_if
// Purpose  : Master request bus plus split-data SRAM pins of the arbiter.
// Revision : 1.0  initial release
// ============================================================================
interface mem_arbiter_if #(
   parameter int NUM_CH = 4,
   parameter int ADDR_W = 20
);
   logic [NUM_CH-1:0]        req;
   logic [NUM_CH-1:0]        we;
   logic [NUM_CH*ADDR_W-1:0] addr;
   logic [NUM_CH*16-1:0]     wdata;
   logic [NUM_CH*2-1:0]      be;
   logic [NUM_CH-1:0]        ack;
   logic [15:0]              rdata;
   logic                     busy;
   logic [2:0]               grant_id;
   logic [ADDR_W-2:0]        sramAddr;
   logic [31:0]              sram_dout;
   logic [31:0]              sram_din;
   logic                     sram_doe;
   logic                     _sramCE;
   logic                     _sramOE;
   logic                     _sramWE;
   logic [3:0]               _sramDS;

   modport master (
      output req, we, addr, wdata, be, sram_din,
      input  ack, rdata, busy, grant_id, sramAddr, sram_dout, sram_doe,
             _sramCE, _sramOE, _sramWE, _sramDS
   );

   modport slave (
      input  req, we, addr, wdata, be, sram_din,
      output ack, rdata, busy, grant_id, sramAddr, sram_dout, sram_doe,
             _sramCE, _sramOE, _sramWE, _sramDS
   );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : N-channel 16-bit master arbiter onto a 32-bit asynchronous SRAM.
// Revision : 1.0  initial release
// ============================================================================
module mem_arbiter #(
   parameter int NUM_CH     = 4,
   parameter int ADDR_W     = 20,
   parameter int ACC_CYCLES = 2,
   parameter int RR         = 0
) (
   input  wire           clk64,
   input  wire           reset,
   mem_arbiter_if.slave  bus
);
   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETUP  = 2'd1,
      S_ACCESS = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   localparam logic [2:0] C_CNT_LAST = 3'(ACC_CYCLES - 1);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [2:0]        r_cnt;
   logic [2:0]        w_cnt_nxt;
   logic [2:0]        w_win;
   logic              w_grant;
   logic              r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [15:0]       r_wdata;
   logic [1:0]        r_be;
   logic [2:0]        r_grant;
   logic [15:0]       r_rdata;
   logic              w_sel_we;
   logic [ADDR_W-1:0] w_sel_addr;
   logic [15:0]       w_sel_wdata;
   logic [1:0]        w_sel_be;
   logic [3:0]        w_ds;
   logic [1:0]        w_ds_half;

   assign w_grant     = (r_state == S_IDLE) && (|bus.req);
   assign w_sel_we    = 1'(bus.we >> w_win);
   assign w_sel_addr  = ADDR_W'(bus.addr >> (32'(w_win) * ADDR_W));
   assign w_sel_wdata = 16'(bus.wdata >> (32'(w_win) * 16));
   assign w_sel_be    = 2'(bus.be >> (32'(w_win) * 2));

   generate
      if (RR != 0) begin : g_rr
         localparam logic [2:0] C_PTR_RST = 3'(NUM_CH - 1);
         logic [2:0] r_last;

         // Rotating search starting just past the previous winner.
         always_comb begin : p_pick_rr
            int                idx;
            logic              found;
            logic [NUM_CH-1:0] sh;
            w_win = 3'd0;
            found = 1'b0;
            idx   = 0;
            sh    = '0;
            for (int k = 1; k <= NUM_CH; k++) begin
               idx = int'(r_last) + k;
               if (idx >= NUM_CH) idx = idx - NUM_CH;
               sh = bus.req >> idx;
               if (!found && sh[0]) begin
                  w_win = 3'(idx);
                  found = 1'b1;
               end
            end
         end

         always_ff @(posedge clk64) begin
            if (reset)        r_last <= C_PTR_RST;
            else if (w_grant) r_last <= w_win;
         end
      end else begin : g_fixed
         always_comb begin : p_pick_fixed
            logic [NUM_CH-1:0] sh;
            w_win = 3'd0;
            sh    = '0;
            for (int i = NUM_CH - 1; i >= 0; i--) begin
               sh = bus.req >> i;
               if (sh[0]) w_win = 3'(i);
            end
         end
      end
   endgenerate

   always_ff @(posedge clk64) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_cnt   <= 3'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Writes enable only the requested bytes; reads always open the whole half.
   assign w_ds_half = r_we ? ~r_be : 2'b00;
   assign w_ds      = r_addr[0] ? {2'b11, w_ds_half} : {w_ds_half, 2'b11};

   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      bus._sramCE  = 1'b1;
      bus._sramOE  = 1'b1;
      bus._sramWE  = 1'b1;
      bus._sramDS  = 4'hF;
      bus.sram_doe = 1'b0;
      bus.ack      = '0;
      case (r_state)
         S_IDLE: begin
            if (|bus.req) w_state_nxt = S_SETUP;
         end
         S_SETUP: begin
            w_state_nxt  = S_ACCESS;
            w_cnt_nxt    = 3'd0;
            bus._sramCE  = 1'b0;
            bus._sramOE  = r_we;
            bus._sramDS  = w_ds;
            bus.sram_doe = r_we;
         end
         S_ACCESS: begin
            bus._sramCE  = 1'b0;
            bus._sramOE  = r_we;
            bus._sramWE  = ~r_we;
            bus._sramDS  = w_ds;
            bus.sram_doe = r_we;
            if (r_cnt == C_CNT_LAST) begin
               w_state_nxt = S_DONE;
               w_cnt_nxt   = 3'd0;
            end else begin
               w_cnt_nxt = r_cnt + 3'd1;
            end
         end
         S_DONE: begin
            w_state_nxt  = S_IDLE;
            bus.sram_doe = r_we;
            bus.ack      = NUM_CH'(1) << r_grant;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk64) begin
      if (reset) begin
         r_grant <= 3'd0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= 16'd0;
         r_be    <= 2'b00;
         r_rdata <= 16'd0;
      end else begin
         if (w_grant) begin
            r_grant <= w_win;
            r_we    <= w_sel_we;
            r_addr  <= w_sel_addr;
            r_wdata <= w_sel_wdata;
            r_be    <= w_sel_be;
         end
         if ((r_state == S_ACCESS) && (r_cnt == C_CNT_LAST) && !r_we)
            r_rdata <= r_addr[0] ? bus.sram_din[15:0] : bus.sram_din[31:16];
      end
   end

   assign bus.busy      = (r_state != S_IDLE);
   assign bus.grant_id  = r_grant;
   assign bus.sramAddr  = r_addr[ADDR_W-1:1];
   assign bus.sram_dout = {r_wdata, r_wdata};
   assign bus.rdata     = r_rdata;
endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Randomized transaction-level check of four arbiter builds.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;
   localparam int NCH  = 4;
   localparam int AW   = 20;
   localparam int NCYC = 700;

   logic clk64 = 1'b0;
   always #5 clk64 = ~clk64;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   for (genvar G = 0; G < 4; G++) begin : g_cfg
      localparam int ACC = (G == 2) ? 1 : (G == 3) ? 7 : 2;
      localparam int RRV = (G == 1 || G == 3) ? 1 : 0;

      logic        rst = 1'b1;
      bit          fin = 1'b0;
      logic [31:0] mem32 [32];

      mem_arbiter_if #(.NUM_CH(NCH), .ADDR_W(AW)) bus ();

      mem_arbiter #(
         .NUM_CH(NCH), .ADDR_W(AW), .ACC_CYCLES(ACC), .RR(RRV)
      ) u_dut (
         .clk64 (clk64),
         .reset (rst),
         .bus   (bus)
      );

      assign bus.sram_din = mem32[bus.sramAddr[4:0]];

      initial begin : p_stim
         logic [15:0]   wmem [64];
         logic [NCH-1:0] pend;
         logic [NCH-1:0] exp_ack;
         int            free_at, last, t_g, ch_g, ph, found, idx;
         bit            active, rst_done, chk_rst, strobe_on;
         logic          we_g;
         logic [AW-1:0] addr_g;
         logic [15:0]   wd_g;
         logic [1:0]    be_g;
         logic [15:0]   m_rdata;
         logic [3:0]    exp_ds;
         logic [8:0]    exp_str, obs_str;
         string         pfx;

         // Shared backing store seen as 32-bit SRAM by the DUT, 16-bit words by the model.
         for (int i = 0; i < 32; i++) begin
            mem32[i]       = $urandom;
            wmem[2*i]      = mem32[i][31:16];
            wmem[2*i + 1]  = mem32[i][15:0];
         end
         bus.req = '0; bus.we = '0; bus.addr = '0; bus.wdata = '0; bus.be = '0;
         pend = '0; active = 0; rst_done = 0; chk_rst = 1; m_rdata = 16'd0;
         last = NCH - 1; free_at = 0; t_g = 0; ch_g = 0;
         we_g = 0; addr_g = '0; wd_g = '0; be_g = '0;
         repeat (2) @(posedge clk64);

         for (int c = 0; c < NCYC; c++) begin
            @(negedge clk64);
            rst = 1'b0;
            pfx = $sformatf("cfg%0d cyc%0d", G, c);
            ph  = active ? (c - t_g) : -1;

            if (!bus._sramCE && !bus._sramWE)
               for (int b = 0; b < 4; b++)
                  if (!bus._sramDS[b])
                     mem32[bus.sramAddr[4:0]][b*8 +: 8] = bus.sram_dout[b*8 +: 8];

            if (ph == ACC + 2) begin
               if (we_g) begin
                  if (be_g[1]) wmem[addr_g[5:0]][15:8] = wd_g[15:8];
                  if (be_g[0]) wmem[addr_g[5:0]][7:0]  = wd_g[7:0];
               end else begin
                  m_rdata = wmem[addr_g[5:0]];
               end
            end

            strobe_on = (ph >= 1) && (ph <= ACC + 1);
            exp_ds = 4'hF;
            if (strobe_on)
               for (int b = 0; b < 4; b++)
                  if (((b >= 2) == (addr_g[0] == 1'b0)) && (!we_g || be_g[b % 2]))
                     exp_ds[b] = 1'b0;
            exp_str = {((ph >= 1) && (ph <= ACC + 2)),
                       !strobe_on,
                       !(strobe_on && !we_g),
                       !((ph >= 2) && (ph <= ACC + 1) && we_g),
                       ((ph >= 1) && (ph <= ACC + 2) && we_g),
                       exp_ds};
            obs_str = {bus.busy, bus._sramCE, bus._sramOE, bus._sramWE, bus.sram_doe, bus._sramDS};
            exp_ack = (ph == ACC + 2) ? (NCH'(1) << ch_g) : '0;

            check({pfx, " strobes"}, 32'(obs_str), 32'(exp_str));
            check({pfx, " ack"}, 32'(bus.ack), 32'(exp_ack));
            check({pfx, " rdata"}, 32'(bus.rdata), 32'(m_rdata));
            if (ph == 1) begin
               check({pfx, " grant_id"}, 32'(bus.grant_id), 32'(ch_g));
               check({pfx, " sramAddr"}, 32'(bus.sramAddr), 32'(addr_g >> 1));
               if (we_g) check({pfx, " sram_dout"}, bus.sram_dout, {wd_g, wd_g});
            end
            if (chk_rst) begin
               check({pfx, " rst grant_id"}, 32'(bus.grant_id), 32'd0);
               check({pfx, " rst sramAddr"}, 32'(bus.sramAddr), 32'd0);
               check({pfx, " rst sram_dout"}, bus.sram_dout, 32'd0);
               chk_rst = 0;
            end

            if (ph == ACC + 2) begin
               active = 0;
               pend[ch_g] = 1'b0;
               bus.req[ch_g] = 1'b0;
            end

            // The granted master may walk away and scribble its inputs mid-access.
            if (strobe_on && $urandom_range(3) == 0) begin
               bus.req[ch_g] = 1'b0;
               bus.we[ch_g]  = 1'($urandom);
               bus.addr[ch_g*AW +: AW]  = AW'($urandom);
               bus.wdata[ch_g*16 +: 16] = 16'($urandom);
               bus.be[ch_g*2 +: 2]      = 2'($urandom);
            end

            for (int i = 0; i < NCH; i++) begin
               if (!pend[i] && (c < 60 || $urandom_range(3) == 0)) begin
                  pend[i]    = 1'b1;
                  bus.req[i] = 1'b1;
                  bus.we[i]  = 1'($urandom);
                  bus.addr[i*AW +: AW]  = AW'($urandom);
                  bus.wdata[i*16 +: 16] = 16'($urandom);
                  bus.be[i*2 +: 2]      = 2'($urandom);
               end
            end

            if (!rst_done && c >= 300 && active && ph == 2) begin
               rst = 1'b1;
               rst_done = 1; chk_rst = 1;
               if (we_g) begin
                  if (be_g[1]) wmem[addr_g[5:0]][15:8] = wd_g[15:8];
                  if (be_g[0]) wmem[addr_g[5:0]][7:0]  = wd_g[7:0];
               end
               active = 0; last = NCH - 1; m_rdata = 16'd0; free_at = c + 1;
               bus.req[ch_g] = 1'b1;
               bus.we[ch_g]  = we_g;
               bus.addr[ch_g*AW +: AW]  = addr_g;
               bus.wdata[ch_g*16 +: 16] = wd_g;
               bus.be[ch_g*2 +: 2]      = be_g;
            end

            if (!rst && c >= free_at && (|bus.req)) begin
               found = -1;
               for (int k = 0; k < NCH; k++) begin
                  idx = (RRV != 0) ? (last + 1 + k) % NCH : k;
                  if (found < 0 && bus.req[idx]) found = idx;
               end
               ch_g    = found;
               we_g    = bus.we[found];
               addr_g  = bus.addr[found*AW +: AW];
               wd_g    = bus.wdata[found*16 +: 16];
               be_g    = bus.be[found*2 +: 2];
               t_g     = c;
               active  = 1;
               last    = found;
               free_at = c + ACC + 3;
            end
         end
         fin = 1'b1;
      end
   end

   initial begin : p_main
      logic all_fin;
      all_fin = 1'b0;
      for (int i = 0; i < 3000 && !all_fin; i++) begin
         @(posedge clk64);
         all_fin = g_cfg[0].fin && g_cfg[1].fin && g_cfg[2].fin && g_cfg[3].fin;
      end
      check("run complete", 32'(all_fin), 32'd1);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
`default_nettype wire
